lcd_text_buffer: RTL and testbench

LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

---
 rtl/lcd_text_pkg.sv | 25 ++
 rtl/lcd_text_buffer.sv | 195 +++++++++++++++++++
 tb/tb_lcd_text_buffer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_pkg.sv
// lcd_text_pkg: shared constants and FSM state type for lcd_text_buffer.
//   COLS            - characters per LCD row
//   LF/BS/FF        - control codes handled by the buffer
//   UNDERSCORE      - cursor marker glyph
//   PRINT_LO/HI     - printable ASCII range written into the buffer
//   state_t         - refresh handshake FSM states
package lcd_text_pkg;

  localparam int COLS = 16;

  localparam logic [7:0] LF         = 8'h0A;
  localparam logic [7:0] BS         = 8'h08;
  localparam logic [7:0] FF         = 8'h0C;
  localparam logic [7:0] UNDERSCORE = 8'h5F;

  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h7E;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFRESH   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: two-row, 16-column character buffer for a text LCD.
// Accepts a character stream (printable ASCII plus LF/BS/FF controls),
// maintains the screen contents and cursor, and requests a redraw from the
// downstream LCD controller whenever the contents change.
//
// Ports:
//   clk          - system clock
//   reset_btn    - asynchronous active-low reset
//   char_valid   - upstream character strobe
//   char_data    - ASCII character or control code
//   char_ready   - character accepted this cycle (high only in IDLE)
//   lcd_ready    - LCD controller idle
//   lcd_refresh  - redraw request, high in REFRESH
//   line1/line2  - top/bottom row, column c at [127-8c -: 8]
//   cursor_row   - 0 = top row
//   cursor_col   - 0..15
//
// Optional feature: define LCD_TEXT_BUFFER_CURSOR_MARK_EN to overlay an
// underscore at the cursor cell on line1/line2 (stored buffer untouched).
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter int         ACK_TIMEOUT = 1000,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic         clk,
  input  logic         reset_btn,
  input  logic         char_valid,
  input  logic [7:0]   char_data,
  output logic         char_ready,
  input  logic         lcd_ready,
  output logic         lcd_refresh,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         cursor_row,
  output logic [3:0]   cursor_col
);

  // Index 0 is the leftmost column and lands in the MSBs when flattened.
  typedef logic [0:COLS-1][7:0] row_t;

  localparam row_t BLANK_ROW = {COLS{BLANK_CHAR}};
  localparam int   CNT_W     = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]       COL_LAST = 4'(COLS - 1);

  state_t           state, state_n;
  row_t             row0_q, row1_q, row0_n, row1_n;
  logic             cur_row, row_n;
  logic [3:0]       cur_col, col_n;
  logic             dirty;
  logic [CNT_W-1:0] tmo_cnt;
  logic             acc, chg, adv_line, start_ref, timed_out;

  assign acc       = char_valid && char_ready;
  assign start_ref = (state == IDLE) && dirty && lcd_ready;
  assign timed_out = (state == REFRESH) && lcd_ready && (tmo_cnt == CNT_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) state <= IDLE;
    else            state <= state_n;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (dirty && lcd_ready) state_n = REFRESH;
      REFRESH:   if (!lcd_ready)         state_n = WAIT_DONE;
                 else if (timed_out)     state_n = IDLE;
      WAIT_DONE: if (lcd_ready)          state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // char_ready is gated by reset so it reads 0 for the whole reset window.
  always_comb begin
    lcd_refresh = (state == REFRESH);
    char_ready  = reset_btn && (state == IDLE);
  end

  // ---------------- character decode / buffer update ----------------
  always_comb begin
    row0_n   = row0_q;
    row1_n   = row1_q;
    row_n    = cur_row;
    col_n    = cur_col;
    chg      = 1'b0;
    adv_line = 1'b0;
    if (acc) begin
      if (char_data >= PRINT_LO && char_data <= PRINT_HI) begin
        chg = 1'b1;
        if (cur_row) row1_n[cur_col] = char_data;
        else         row0_n[cur_col] = char_data;
        if (cur_col == COL_LAST) adv_line = 1'b1;
        else                     col_n    = cur_col + 4'd1;
      end else begin
        case (char_data)
          LF: begin
            chg      = 1'b1;
            adv_line = 1'b1;
          end
          BS: begin
            if (cur_col != 4'd0) begin
              chg   = 1'b1;
              col_n = cur_col - 4'd1;
              if (cur_row) row1_n[cur_col - 4'd1] = BLANK_CHAR;
              else         row0_n[cur_col - 4'd1] = BLANK_CHAR;
            end else if (cur_row) begin
              chg              = 1'b1;
              row_n            = 1'b0;
              col_n            = COL_LAST;
              row0_n[COL_LAST] = BLANK_CHAR;
            end
          end
          FF: begin
            chg    = 1'b1;
            row0_n = BLANK_ROW;
            row1_n = BLANK_ROW;
            row_n  = 1'b0;
            col_n  = 4'd0;
          end
          default: ;
        endcase
      end
    end
    // Line advance after the write so a scroll carries the char just
    // written into column 15 up into the top row.
    if (adv_line) begin
      col_n = 4'd0;
      if (!cur_row) begin
        row_n = 1'b1;
      end else begin
        row0_n = row1_n;
        row1_n = BLANK_ROW;
      end
    end
  end

  // ---------------- state registers ----------------
  // Buffer/cursor only move on an accepted char, which requires IDLE, so the
  // lines are frozen for the whole refresh handshake.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      row0_q  <= BLANK_ROW;
      row1_q  <= BLANK_ROW;
      cur_row <= 1'b0;
      cur_col <= 4'd0;
    end else begin
      row0_q  <= row0_n;
      row1_q  <= row1_n;
      cur_row <= row_n;
      cur_col <= col_n;
    end
  end

  // dirty comes out of reset set so the blank screen gets pushed. A char
  // landing on the refresh-start edge is already in the lines being sent.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn)        dirty <= 1'b1;
    else if (start_ref)    dirty <= 1'b0;
    else if (timed_out)    dirty <= 1'b1;
    else if (acc && chg)   dirty <= 1'b1;
  end

  // Counts cycles spent in REFRESH; zero on every entry.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn)                                     tmo_cnt <= '0;
    else if (state == REFRESH && state_n == REFRESH)    tmo_cnt <= tmo_cnt + 1'b1;
    else                                                tmo_cnt <= '0;
  end

  assign cursor_row = cur_row;
  assign cursor_col = cur_col;

`ifdef LCD_TEXT_BUFFER_CURSOR_MARK_EN
  row_t disp0, disp1;
  always_comb begin
    disp0 = row0_q;
    disp1 = row1_q;
    if (reset_btn) begin
      if (cur_row) disp1[cur_col] = UNDERSCORE;
      else         disp0[cur_col] = UNDERSCORE;
    end
  end
  assign line1 = disp0;
  assign line2 = disp1;
`else
  assign line1 = row0_q;
  assign line2 = row1_q;
`endif

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Self-checking bench for lcd_text_buffer (default build, marker disabled).
module tb_lcd_text_buffer;

  localparam int TMO = 20;
  localparam logic [127:0] BLANK128 = {16{8'h20}};

  logic         clk = 1'b0;
  logic         reset_btn = 1'b0;
  logic         char_valid = 1'b0;
  logic [7:0]   char_data = 8'h00;
  logic         char_ready;
  logic         lcd_ready;
  logic         lcd_refresh;
  logic [127:0] line1, line2;
  logic         cursor_row;
  logic [3:0]   cursor_col;

  // LCD controller stand-in: manual level or an auto responder that drops
  // ready for a few cycles whenever a redraw is requested.
  logic lcd_auto = 1'b0, lcd_level = 1'b1, auto_rdy = 1'b1;
  int   busy = 0;
  assign lcd_ready = lcd_auto ? auto_rdy : lcd_level;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_text_buffer #(.ACK_TIMEOUT(TMO), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .reset_btn(reset_btn), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .lcd_ready(lcd_ready),
    .lcd_refresh(lcd_refresh), .line1(line1), .line2(line2),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  initial begin
    forever begin
      @(negedge clk);
      if (busy > 0) begin
        busy--;
        if (busy == 0) auto_rdy = 1'b1;
      end else if (lcd_auto && lcd_refresh) begin
        auto_rdy = 1'b0;
        busy     = 3;
      end
    end
  end

  // ---------------- model + scoreboard ----------------
  typedef struct {
    logic [127:0] l1, l2;
    logic         r;
    logic [3:0]   c;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] m [2][16];
  int mr, mc;

  function automatic logic [127:0] pack_row(input int r);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = m[r][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) m[r][i] = 8'h20;
    mr = 0; mc = 0;
  endtask

  task automatic model_newline();
    if (mr == 0) mr = 1;
    else for (int i = 0; i < 16; i++) begin
      m[0][i] = m[1][i];
      m[1][i] = 8'h20;
    end
    mc = 0;
  endtask

  task automatic model_apply(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      m[mr][mc] = ch;
      if (mc == 15) model_newline(); else mc++;
    end else if (ch == 8'h0A) model_newline();
    else if (ch == 8'h08) begin
      if (mc > 0) begin mc--; m[mr][mc] = 8'h20; end
      else if (mr == 1) begin mr = 0; mc = 15; m[0][15] = 8'h20; end
    end else if (ch == 8'h0C) model_reset();
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one character at a negedge, let it be accepted, compare at the
  // following negedge against the scoreboard entry.
  task automatic send(input logic [7:0] ch);
    int n = 0;
    exp_t e, g;
    while (!char_ready && n < 200) begin @(negedge clk); n++; end
    if (!char_ready) begin
      chk("char_ready wait", {255'd0, char_ready}, 256'd1);
      return;
    end
    char_valid = 1'b1;
    char_data  = ch;
    model_apply(ch);
    e.l1 = pack_row(0); e.l2 = pack_row(1);
    e.r  = mr[0];       e.c  = mc[3:0];
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    g = sbq.pop_front();
    chk("sb line1", line1, g.l1);
    chk("sb line2", line2, g.l2);
    chk("sb row", cursor_row, g.r);
    chk("sb col", cursor_col, g.c);
  endtask

  // Wait until the block sits in IDLE with nothing pending (auto mode).
  task automatic quiesce();
    int streak = 0, n = 0;
    while (streak < 4 && n < 300) begin
      @(negedge clk); n++;
      if (char_ready && !lcd_refresh && lcd_ready) streak++; else streak = 0;
    end
    chk("quiesce", streak, 4);
  endtask

  typedef struct {
    logic [7:0] ch;
    logic       row;
    logic [3:0] col;
  } vec_t;
  vec_t tbl[12];

  initial begin
    string s_morse, s_up, s_lo;
    logic [127:0] k;
    int c0, hi, n;

    tbl[0]  = '{8'h08, 1'b0, 4'd15};
    tbl[1]  = '{8'h08, 1'b0, 4'd14};
    tbl[2]  = '{8'h0A, 1'b1, 4'd0};
    tbl[3]  = '{8'h78, 1'b1, 4'd1};
    tbl[4]  = '{8'h07, 1'b1, 4'd1};
    tbl[5]  = '{8'h7F, 1'b1, 4'd1};
    tbl[6]  = '{8'h7E, 1'b1, 4'd2};
    tbl[7]  = '{8'h1F, 1'b1, 4'd2};
    tbl[8]  = '{8'h0A, 1'b1, 4'd0};
    tbl[9]  = '{8'h0C, 1'b0, 4'd0};
    tbl[10] = '{8'h08, 1'b0, 4'd0};
    tbl[11] = '{8'h20, 1'b0, 4'd1};

    s_morse = "Morse Translator";
    s_up    = "ABCDEFGHIJKLMNOP";
    s_lo    = "abcdefghijklmnop";
    model_reset();

    // Reset state, sampled between edges.
    #12;
    chk("rst lcd_refresh", lcd_refresh, 0);
    chk("rst char_ready", char_ready, 0);
    chk("rst line1", line1, BLANK128);
    chk("rst line2", line2, BLANK128);
    chk("rst cursor", {cursor_row, cursor_col}, 0);

    // Release with lcd_ready high: refresh asserted one edge later.
    @(negedge clk); reset_btn = 1'b1;
    @(negedge clk);
    chk("first refresh", lcd_refresh, 1);
    chk("ready in refresh", char_ready, 0);
    chk("first line1", line1, BLANK128);
    lcd_auto = 1'b1;

    for (int i = 0; i < 16; i++) send(s_morse[i]);
    k = "Morse Translator";
    chk("morse line1", line1, k);
    chk("morse line2", line2, BLANK128);
    chk("morse cursor", {cursor_row, cursor_col}, {1'b1, 4'd0});

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].ch);
      chk("tbl row", cursor_row, tbl[i].row);
      chk("tbl col", cursor_col, tbl[i].col);
      if (i == 0) chk("bs wrap blank", line1[7:0], 8'h20);
    end

    // Fill both rows with ready low: one char per cycle, then scroll.
    quiesce();
    lcd_auto = 1'b0; lcd_level = 1'b0;
    send(8'h0C);
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(s_up[i]);
    for (int i = 0; i < 16; i++) send(s_lo[i]);
    chk("throughput", cyc - c0, 32);
    send(8'h41);
    k = "abcdefghijklmnop";
    chk("scroll line1", line1, k);
    k = "A               ";
    chk("scroll line2", line2, k);
    chk("scroll cursor", {cursor_row, cursor_col}, {1'b1, 4'd1});

    // Backspace at 0/0 must not trigger a redraw.
    lcd_auto = 1'b1;
    quiesce();
    send(8'h0C);
    quiesce();
    send(8'h08);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lcd_refresh) hi++;
    end
    chk("bs noop refresh", hi, 0);

    // Timeout: ready held high through REFRESH.
    lcd_auto = 1'b0; lcd_level = 1'b1;
    send(8'h5A);
    n = 0;
    while (!lcd_refresh && n < 10) begin @(negedge clk); n++; end
    hi = 0;
    while (lcd_refresh && hi < 1000) begin hi++; @(negedge clk); end
    chk("timeout len", hi, TMO);
    chk("timeout idle", char_ready, 1);
    @(negedge clk);
    chk("timeout reassert", lcd_refresh, 1);

    // Reset during WAIT_DONE, then during REFRESH.
    lcd_level = 1'b0;
    @(negedge clk);
    chk("wait_done refresh", lcd_refresh, 0);
    chk("wait_done ready", char_ready, 0);
    chk("pre-reset line1", line1, pack_row(0));
    #2 reset_btn = 1'b0;
    #1;
    chk("async lcd_refresh", lcd_refresh, 0);
    chk("async char_ready", char_ready, 0);
    chk("async line1", line1, BLANK128);
    chk("async line2", line2, BLANK128);
    chk("async cursor", {cursor_row, cursor_col}, 0);
    @(negedge clk);
    lcd_level = 1'b1; reset_btn = 1'b1;
    #1 chk("post-reset ready", char_ready, 1);
    @(negedge clk);
    chk("refresh after reset", lcd_refresh, 1);
    #2 reset_btn = 1'b0;
    #1 chk("reset drops refresh", lcd_refresh, 0);
    @(negedge clk); reset_btn = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
